// File: rtl/match_filter_pkg.sv
// Shared constants and state encoding for the matched-filter FIR controller.
package match_filter_pkg;

    // Template length swept per sample. Must not exceed DEPTH.
    localparam int TAPS    = 101;
    // Datapath sample ring depth. Must be a power of two.
    localparam int DEPTH   = 128;
    // Clocks from the last MAC enable until the accumulator is final.
    localparam int MAC_LAT = 2;

    localparam int COEFF_W = 8;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(TAPS + 1);
    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [IDX_W-1:0]   LAST_TAP  = IDX_W'(TAPS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SWEEP,
        ST_DRAIN,
        ST_CAPTURE
    } state_t;

    // True when a template address names a stored coefficient.
    function automatic logic tap_in_range(input logic [IDX_W-1:0] addr);
        return int'(addr) < TAPS;
    endfunction

endpackage

// File: rtl/match_coeff_ram.sv
// Template coefficient store: TAPS x COEFF_W single-port RAM, one-cycle read.
module match_coeff_ram
    import match_filter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [IDX_W-1:0]   addr,
    input  logic [COEFF_W-1:0] wdata,
    output logic [COEFF_W-1:0] q
);

    logic [COEFF_W-1:0] mem [TAPS];

    // Template write from the config side.
    // NOTE: the array itself has no reset; the template must survive a
    // controller reset, and a reset here would also stop RAM inference.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register; returns zero on cycles without a read so the
    // coefficient bus idles at 0 outside the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/match_filter_sequencer.sv
// Matched-filter sequencer: per ADC sample, writes the ring, clears the
// accumulator, sweeps the template through the MAC, waits out the MAC
// pipeline and pulses capture. Also owns template loading and overrun.
module match_filter_sequencer
    import match_filter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [COEFF_W-1:0] cfg_data,
    output logic               cfg_ready,
    input  logic               overrun_clr,
    output logic               dp_write,
    output logic               dp_clear,
    output logic               dp_mac_en,
    output logic [IDX_W-1:0]   dp_index,
    output logic [IDX_W-1:0]   dp_offset,
    output logic [COEFF_W-1:0] dp_coeff,
    output logic               dp_capture,
    output logic               primed,
    output logic               busy,
    output logic               overrun
);

    state_t             state;
    logic [IDX_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   sample_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               ram_we;
    logic               ram_re;
    logic [IDX_W-1:0]   rd_addr;
    logic [IDX_W-1:0]   ram_addr;

    // Share the single RAM port: config writes only happen in IDLE and
    // reads only in WRITE/SWEEP, so the two never collide. The read runs
    // one tap ahead so dp_coeff lines up with dp_index.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        ram_re  = 1'b0;
        rd_addr = '0;
        if (state == ST_WRITE) begin
            ram_re = 1'b1;
        end else if (state == ST_SWEEP && dp_index != LAST_TAP) begin
            ram_re  = 1'b1;
            rd_addr = dp_index + IDX_W'(1);
        end
        ram_we   = cfg_we && cfg_ready && !reset && tap_in_range(cfg_addr);
        ram_addr = ram_we ? cfg_addr : rd_addr;
    end

    match_coeff_ram u_coeff_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (cfg_data),
        .q     (dp_coeff)
    );

    // Sequencer FSM with registered datapath controls.
    // NOTE: non-blocking assignments throughout, so every register here
    // sees the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            sample_cnt <= '0;
            drain_cnt  <= '0;
            dp_write   <= 1'b0;
            dp_clear   <= 1'b0;
            dp_mac_en  <= 1'b0;
            dp_index   <= '0;
            dp_offset  <= '0;
            dp_capture <= 1'b0;
            primed     <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            dp_write   <= 1'b0;
            dp_clear   <= 1'b0;
            dp_mac_en  <= 1'b0;
            dp_capture <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ready) begin
                        state     <= ST_WRITE;
                        dp_write  <= 1'b1;
                        dp_clear  <= 1'b1;
                        dp_offset <= wr_ptr;
                        wr_ptr    <= wr_ptr + IDX_W'(1);
                        if (sample_cnt != CNT_W'(TAPS)) begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                        if (sample_cnt == CNT_W'(TAPS - 1)) begin
                            primed <= 1'b1;
                        end
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_SWEEP;
                    dp_mac_en <= 1'b1;
                    dp_index  <= '0;
                end
                ST_SWEEP: begin
                    if (dp_index == LAST_TAP) begin
                        state     <= ST_DRAIN;
                        dp_index  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        dp_mac_en <= 1'b1;
                        dp_index  <= dp_index + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state      <= ST_CAPTURE;
                        dp_capture <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overrun: a ready arriving while busy is dropped and flagged;
    // a coincident clear loses to the new event.
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ready && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_match_filter_sequencer.sv
// Self-checking bench for match_filter_sequencer: a timing vector table for
// one sweep, a scoreboard for write offsets / tap coefficients / captures,
// and directed sequences for config, overrun, reset and wrap corners.
module tb_match_filter_sequencer;
    import match_filter_pkg::*;

    localparam int SWEEP_LEN = TAPS + MAC_LAT + 3;

    logic               clock;
    logic               reset;
    logic               ready;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_addr;
    logic [COEFF_W-1:0] cfg_data;
    logic               cfg_ready;
    logic               overrun_clr;
    logic               dp_write;
    logic               dp_clear;
    logic               dp_mac_en;
    logic [IDX_W-1:0]   dp_index;
    logic [IDX_W-1:0]   dp_offset;
    logic [COEFF_W-1:0] dp_coeff;
    logic               dp_capture;
    logic               primed;
    logic               busy;
    logic               overrun;

    match_filter_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .ready       (ready),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .overrun_clr (overrun_clr),
        .dp_write    (dp_write),
        .dp_clear    (dp_clear),
        .dp_mac_en   (dp_mac_en),
        .dp_index    (dp_index),
        .dp_offset   (dp_offset),
        .dp_coeff    (dp_coeff),
        .dp_capture  (dp_capture),
        .primed      (primed),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model and scoreboard
    typedef struct {
        int         idx;
        logic [7:0] coeff;
    } mac_t;

    logic [7:0] tmpl [TAPS];
    int         m_ptr = 0;
    int         m_cnt = 0;
    int         cap_pending = 0;
    int         exp_wr [$];
    mac_t       exp_mac [$];
    int         cur_off = 0;
    bit         mon_on = 1'b0;

    task automatic push_sweep();
        exp_wr.push_back(m_ptr);
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < TAPS) m_cnt++;
        for (int i = 0; i < TAPS; i++) exp_mac.push_back('{i, tmpl[i]});
        cap_pending++;
    endtask

    task automatic flush_model();
        exp_wr.delete();
        exp_mac.delete();
        cap_pending = 0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Monitor: compare DUT activity against the scoreboard on falling edges.
    mac_t mon_item;
    always @(negedge clock) begin
        if (mon_on) begin
            if (dp_write) begin
                if (exp_wr.size() == 0) begin
                    check("sb_unexpected_write", dp_write, 0);
                end else begin
                    cur_off = exp_wr.pop_front();
                    check("sb_offset", dp_offset, cur_off);
                    check("sb_clear_with_write", dp_clear, 1);
                end
            end
            if (dp_mac_en) begin
                if (exp_mac.size() == 0) begin
                    check("sb_unexpected_mac", dp_mac_en, 0);
                end else begin
                    mon_item = exp_mac.pop_front();
                    check("sb_index", dp_index, mon_item.idx);
                    check("sb_coeff", dp_coeff, mon_item.coeff);
                    check("sb_offset_held", dp_offset, cur_off);
                end
            end
            if (dp_capture) begin
                if (cap_pending == 0) check("sb_unexpected_capture", dp_capture, 0);
                else cap_pending--;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic cfg_write(input int a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = IDX_W'(a);
        cfg_data = d;
        if (a < TAPS) tmpl[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // One sweep starting in IDLE; optional config write at cycle cfg_cyc.
    // A write at cycle 0 lands in IDLE and must be seen by this sweep.
    task automatic run_sweep(input int cfg_cyc, input int a, input logic [7:0] d);
        check("primed_before_write", primed, (m_cnt >= TAPS));
        ready = 1'b1;
        if (cfg_cyc == 0) begin
            cfg_we   = 1'b1;
            cfg_addr = IDX_W'(a);
            cfg_data = d;
            if (a < TAPS) tmpl[a] = d;
        end
        push_sweep();
        tick();
        ready  = 1'b0;
        cfg_we = 1'b0;
        check("primed_at_write", primed, (m_cnt >= TAPS));
        for (int c = 1; c < SWEEP_LEN; c++) begin
            if (c == cfg_cyc) begin
                cfg_we   = 1'b1;
                cfg_addr = IDX_W'(a);
                cfg_data = d;
            end
            tick();
            cfg_we = 1'b0;
        end
        check("idle_after_sweep", busy, 0);
    endtask

    // Cycle-indexed vectors for one sweep with overrun corner cases.
    typedef struct {
        int cyc;
        bit rdy;
        bit clr;
        bit e_wr;
        bit e_clr;
        bit e_mac;
        bit e_cap;
        bit e_busy;
        bit e_ovr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial begin
        vecs = '{
            '{  0, 1, 0,  0, 0, 0, 0, 0, 0 },
            '{  1, 0, 0,  1, 1, 0, 0, 1, 0 },
            '{  2, 0, 0,  0, 0, 1, 0, 1, 0 },
            '{ 50, 1, 0,  0, 0, 1, 0, 1, 0 },
            '{ 51, 0, 0,  0, 0, 1, 0, 1, 1 },
            '{ 60, 0, 1,  0, 0, 1, 0, 1, 1 },
            '{ 61, 0, 0,  0, 0, 1, 0, 1, 0 },
            '{ 70, 1, 1,  0, 0, 1, 0, 1, 0 },
            '{ 71, 0, 0,  0, 0, 1, 0, 1, 1 },
            '{ 80, 0, 1,  0, 0, 1, 0, 1, 1 },
            '{ 81, 0, 0,  0, 0, 1, 0, 1, 0 },
            '{102, 0, 0,  0, 0, 1, 0, 1, 0 },
            '{103, 0, 0,  0, 0, 0, 0, 1, 0 },
            '{104, 0, 0,  0, 0, 0, 0, 1, 0 },
            '{105, 1, 0,  0, 0, 0, 1, 1, 0 },
            '{106, 0, 0,  0, 0, 0, 0, 0, 1 },
            '{107, 0, 1,  0, 0, 0, 0, 0, 1 },
            '{108, 0, 0,  0, 0, 0, 0, 0, 0 }
        };

        reset       = 1'b1;
        ready       = 1'b0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        overrun_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        flush_model();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_primed", primed, 0);
        check("rst_overrun", overrun, 0);
        check("rst_write", dp_write, 0);
        check("rst_mac", dp_mac_en, 0);
        check("rst_capture", dp_capture, 0);
        check("rst_offset", dp_offset, 0);
        check("rst_index", dp_index, 0);
        check("rst_coeff", dp_coeff, 0);
        mon_on = 1'b1;

        // Load template[i] = i+1
        for (int i = 0; i < TAPS; i++) cfg_write(i, 8'(i + 1));

        // Timing table sweep: landmarks plus dropped readys and clears
        for (int c = 0; c <= 108; c++) begin
            ready       = 1'b0;
            overrun_clr = 1'b0;
            for (int v = 0; v < NVEC; v++) begin
                if (vecs[v].cyc == c) begin
                    check($sformatf("c%0d_write", c), dp_write, vecs[v].e_wr);
                    check($sformatf("c%0d_clear", c), dp_clear, vecs[v].e_clr);
                    check($sformatf("c%0d_mac", c), dp_mac_en, vecs[v].e_mac);
                    check($sformatf("c%0d_capture", c), dp_capture, vecs[v].e_cap);
                    check($sformatf("c%0d_busy", c), busy, vecs[v].e_busy);
                    check($sformatf("c%0d_cfg_ready", c), cfg_ready, !vecs[v].e_busy);
                    check($sformatf("c%0d_overrun", c), overrun, vecs[v].e_ovr);
                    if (!vecs[v].e_mac) begin
                        check($sformatf("c%0d_index_idle", c), dp_index, 0);
                        check($sformatf("c%0d_coeff_idle", c), dp_coeff, 0);
                    end
                    ready       = vecs[v].rdy;
                    overrun_clr = vecs[v].clr;
                    if (c == 0) push_sweep();
                end
            end
            tick();
        end
        ready       = 1'b0;
        overrun_clr = 1'b0;

        // Dropped readys must not have advanced the pointer: next offset is 1
        run_sweep(-1, 0, 8'h00);

        // Config write during SWEEP is ignored; same write in IDLE takes effect
        run_sweep(20, 5, 8'h7F);
        run_sweep(-1, 0, 8'h00);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_write(5, 8'h7F);
        run_sweep(-1, 0, 8'h00);

        // Out-of-range writes ignored; in-range write coincident with ready seen
        cfg_write(101, 8'hAA);
        run_sweep(0, 101, 8'h55);
        run_sweep(0, 0, 8'h80);

        // Reset at cycle 60 of a sweep
        ready = 1'b1;
        push_sweep();
        tick();
        ready = 1'b0;
        repeat (59) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_write", dp_write, 0);
        check("mid_rst_clear", dp_clear, 0);
        check("mid_rst_mac", dp_mac_en, 0);
        check("mid_rst_capture", dp_capture, 0);
        check("mid_rst_index", dp_index, 0);
        check("mid_rst_offset", dp_offset, 0);
        check("mid_rst_coeff", dp_coeff, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_primed", primed, 0);
        reset = 1'b0;
        flush_model();
        repeat (60) tick();
        run_sweep(-1, 0, 8'h00);

        // 130 back-to-back samples at minimum spacing: wrap and primed
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush_model();
        for (int k = 0; k < 130; k++) run_sweep(-1, 0, 8'h00);
        check("final_overrun", overrun, 0);
        check("final_offset", dp_offset, 1);
        check("final_primed", primed, 1);

        repeat (4) tick();
        check("sb_writes_left", exp_wr.size(), 0);
        check("sb_macs_left", exp_mac.size(), 0);
        check("sb_captures_left", cap_pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
